phase_slot_scheduler: RTL and testbench
=======================================

Name: phase_slot_scheduler

Overview:
Slot scheduler for one fast clock domain that receives a per-domain phase indicator (one-cycle pulse on the first fast cycle of each sync-clock period).
- Verifies the phase pulse is periodic and declares lock.
- Tracks the slot index within the sync period.
- Round-robin grants one requester per sync period, at a fixed safe slot, for slow-domain transfers.
- Sits directly downstream of the phase generator, one instance per fast domain.

Parameters:
MULT, 4, fast clock cycles per sync period; legal 2..16.
NUM_REQ, 4, number of requesters; legal 1..8.
LOCK_COUNT, 3, consecutive correctly placed phase pulses needed to lock; legal 1..15.
GRANT_SLOT, 1, slot index at which gnt_o fires; legal 0..MULT-1.

Ports:
clk_i  input  1  fast clock; phase_i is synchronous to it.
rst_n_i  input  1  asynchronous, active-low reset.
phase_i  input  1  phase pulse, high on slot 0 of each sync period.
req_i  input  NUM_REQ  level requests; requester holds high until granted.
gnt_o  output  NUM_REQ  one-hot, one-cycle grant pulse.
slot_o  output  clog2(MULT)  current slot index, valid when locked_o is high.
locked_o  output  1  phase lock status.
err_cnt_o  output  8  saturating count of phase errors seen while locked.

Behaviour:
- Reset (rst_n_i low, asynchronous): gnt_o=0, slot_o=0, locked_o=0, err_cnt_o=0, state=HUNT, good count=0, round-robin pointer=0.
- Slot counter:
  - Internal count c predicts the current slot: c=0 means phase_i is expected this cycle.
  - c increments modulo MULT every cycle.
  - slot_o is a registered copy of c: it shows 0 in the cycle after phase_i is sampled high (1-cycle latency).
- Mismatch definition: phase_i high while c!=0, or phase_i low while c==0.
- Realign: on any phase_i high outside a match, c is forced so that the next cycle is slot 1.
- FSM:
  - HUNT: phase_i high -> realign, good=1, go to ACQ; if LOCK_COUNT==1, go directly to LOCKED.
  - ACQ:
    - Match with phase_i high -> good+1.
    - When good reaches LOCK_COUNT -> LOCKED.
    - Mismatch -> if phase_i high, realign with good=1 and stay in ACQ; otherwise go to HUNT.
  - LOCKED:
    - Mismatch -> err_cnt_o+1 (saturates at 255), then the same resolution as ACQ (ACQ with good=1 if phase_i high, else HUNT).
- locked_o is registered: high the cycle after the FSM enters LOCKED; low the cycle after leaving it.
- Grant:
  - Evaluated only in LOCKED, in the cycle where the next slot equals GRANT_SLOT.
  - req_i is sampled in that cycle.
  - The winner is the first set bit at or after the pointer, searching cyclically.
  - gnt_o pulses for exactly the cycle where slot_o==GRANT_SLOT.
  - Pointer becomes (winner+1) mod NUM_REQ.
  - No requests -> no grant, pointer unchanged.
  - At most one grant per sync period.
- Simultaneous events: a mismatch in the decision cycle suppresses that period's grant.
- A grant already issued is not revoked.
- req_i dropped before the decision cycle -> no grant for that requester.
- err_cnt_o clears only on reset.

Decomposition:
- Shared package/header holds:
  - FSM state encodings: HUNT=2'd0, ACQ=2'd1, LOCKED=2'd2.
  - Error counter width (8).
  - A clog2 function.
- One sub-module: rr_arbiter (NUM_REQ parameter).
  - Inputs: req, enable, pointer.
  - Outputs: one-hot grant and next pointer.
  - Also reusable by other schedulers.

Test Plan:
(Configuration MULT=4, NUM_REQ=3, LOCK_COUNT=3, GRANT_SLOT=1.)
1. Reset state: release reset with phase_i low and req_i=3'b111 -> all outputs remain 0 indefinitely; no gnt_o ever.
2. Lock acquisition: phase_i pulses at cycles 10, 14, 18, ... -> locked_o first high at cycle 19; slot_o reads 0,1,2,3 repeating from cycle 11.
3. Round-robin fairness: lock, then req_i=3'b111 held -> gnt_o=001, 010, 100, 001 in consecutive periods, each pulse where slot_o==1; then req_i=3'b100 -> gnt_o=100 every period.
4. Early pulse while locked: phase_i one cycle early -> locked_o low the next cycle; err_cnt_o=1; no grant that period; locked_o high again after 2 further correct pulses, i.e. the third counting the early one.
5. Missing pulse while locked: one phase_i pulse omitted -> locked_o drops; err_cnt_o increments; state HUNT; relock after 3 correct pulses; 256 injected errors -> err_cnt_o saturates at 255.
6. Async reset mid-operation: assert rst_n_i low mid-period with gnt_o high -> gnt_o, locked_o, err_cnt_o are 0 immediately, without waiting for a clock edge; pointer restarts at requester 0 after relock.

Source files
------------

// File: rtl/phase_slot_scheduler_pkg.sv
// Shared types and helpers for the phase-locked slot scheduler.
package phase_slot_scheduler_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam int ERR_W = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/phase_slot_scheduler_rr_arbiter.sv
// Cyclic first-set-bit arbiter starting at a pointer; reusable by other schedulers.
module rr_arbiter
    import phase_slot_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int PW = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PW-1:0]      ptr_nxt_o
);

    logic found;

    // Two passes: indices at/after the pointer, then the wrapped ones.
    always_comb begin
        gnt_o     = '0;
        ptr_nxt_o = ptr_i;
        found     = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (en_i && !found && j >= int'(ptr_i) && req_i[j]) begin
                found     = 1'b1;
                gnt_o[j]  = 1'b1;
                ptr_nxt_o = PW'((j + 1 == NUM_REQ) ? 0 : j + 1);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (en_i && !found && j < int'(ptr_i) && req_i[j]) begin
                found     = 1'b1;
                gnt_o[j]  = 1'b1;
                ptr_nxt_o = PW'(j + 1);
            end
        end
    end

endmodule

// File: rtl/phase_slot_scheduler.sv
// Locks onto a periodic phase pulse, tracks the slot index and issues one
// round-robin grant per sync period at a fixed slot.
module phase_slot_scheduler
    import phase_slot_scheduler_pkg::*;
#(
    parameter int MULT       = 4,
    parameter int NUM_REQ    = 4,
    parameter int LOCK_COUNT = 3,
    parameter int GRANT_SLOT = 1,
    localparam int SW = clog2(MULT),
    localparam int PW = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               phase_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [SW-1:0]      slot_o,
    output logic               locked_o,
    output logic [ERR_W-1:0]   err_cnt_o
);

    state_e             state_q, state_d;
    logic [SW-1:0]      c_q, c_d, c_inc;
    logic [SW-1:0]      slot_q, slot_d;
    logic [3:0]         good_q, good_d, good_inc;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               locked_q;
    logic [NUM_REQ-1:0] gnt_q, gnt_c;
    logic [PW-1:0]      ptr_q, ptr_nxt;
    logic               mismatch, arb_en;

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        err_d    = err_q;
        good_inc = good_q + 4'd1;
        mismatch = phase_i ^ (c_q == '0);
        c_inc    = (c_q == SW'(MULT - 1)) ? '0 : c_q + SW'(1);
        unique case (state_q)
            HUNT: begin
                if (phase_i) begin
                    good_d  = 4'd1;
                    state_d = (LOCK_COUNT == 1) ? LOCKED : ACQ;
                end
            end
            ACQ: begin
                if (!mismatch) begin
                    if (phase_i) begin
                        good_d = good_inc;
                        if (good_inc == 4'(LOCK_COUNT)) state_d = LOCKED;
                    end
                end else if (phase_i) begin
                    good_d  = 4'd1;
                    state_d = (LOCK_COUNT == 1) ? LOCKED : ACQ;
                end else begin
                    good_d  = 4'd0;
                    state_d = HUNT;
                end
            end
            LOCKED: begin
                if (mismatch) begin
                    if (err_q != '1) err_d = err_q + 1'b1;
                    if (phase_i) begin
                        good_d  = 4'd1;
                        state_d = (LOCK_COUNT == 1) ? LOCKED : ACQ;
                    end else begin
                        good_d  = 4'd0;
                        state_d = HUNT;
                    end
                end
            end
            default: begin
                good_d  = 4'd0;
                state_d = HUNT;
            end
        endcase
        // Any phase pulse realigns so the following cycle is slot 1.
        c_d    = phase_i ? SW'(1) : ((state_d == HUNT) ? '0 : c_inc);
        slot_d = phase_i ? '0 : c_q;
        arb_en = (state_q == LOCKED) && !mismatch
                 && (slot_d == SW'(GRANT_SLOT));
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i    (req_i),
        .en_i     (arb_en),
        .ptr_i    (ptr_q),
        .gnt_o    (gnt_c),
        .ptr_nxt_o(ptr_nxt)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= HUNT;
            c_q      <= '0;
            slot_q   <= '0;
            good_q   <= '0;
            err_q    <= '0;
            locked_q <= 1'b0;
            gnt_q    <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            slot_q   <= slot_d;
            good_q   <= good_d;
            err_q    <= err_d;
            locked_q <= (state_d == LOCKED);
            gnt_q    <= gnt_c;
            ptr_q    <= ptr_nxt;
        end
    end

    assign gnt_o     = gnt_q;
    assign slot_o    = slot_q;
    assign locked_o  = locked_q;
    assign err_cnt_o = err_q;

endmodule

// File: tb/tb_phase_slot_scheduler.sv
// Directed bench: expected grants go into a queue that a negedge monitor drains.
module tb_phase_slot_scheduler;

    localparam int MULT = 4;
    localparam int NR   = 3;
    localparam int LC   = 3;
    localparam int GS   = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          phase = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] gnt;
    logic [1:0]    slot;
    logic          locked;
    logic [7:0]    err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [NR-1:0] exp_q[$];

    always #5 clk = ~clk;

    phase_slot_scheduler #(
        .MULT(MULT), .NUM_REQ(NR), .LOCK_COUNT(LC), .GRANT_SLOT(GS)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .phase_i  (phase),
        .req_i    (req),
        .gnt_o    (gnt),
        .slot_o   (slot),
        .locked_o (locked),
        .err_cnt_o(err)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (gnt !== '0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_grant: got %b expected none at %0t",
                         gnt, $time);
            end else begin
                chk("grant", 32'(gnt), 32'(exp_q.pop_front()));
                chk("grant_slot", 32'(slot), GS);
            end
        end
    end

    task automatic cyc(input logic ph, input logic [NR-1:0] r);
        phase = ph;
        req   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic period(input logic [NR-1:0] r);
        cyc(1'b1, r);
        repeat (MULT - 1) cyc(1'b0, r);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req = 3'b111;
        #2;
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err", 32'(err), 0);
        #10;
        rst_n = 1'b1;

        // Reset state: no phase, all requesting -> everything stays 0.
        repeat (20) begin
            cyc(1'b0, 3'b111);
            chk("idle_locked", 32'(locked), 0);
            chk("idle_slot", 32'(slot), 0);
            chk("idle_err", 32'(err), 0);
        end

        // Lock acquisition with slot sequence.
        for (int p = 1; p <= LC; p++) begin
            cyc(1'b1, 3'b000);
            chk("acq_slot0", 32'(slot), 0);
            chk("acq_locked", 32'(locked), (p == LC) ? 1 : 0);
            for (int k = 1; k < MULT; k++) begin
                cyc(1'b0, 3'b000);
                chk("acq_slot", 32'(slot), k);
            end
        end

        // Round-robin fairness.
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b001);
        repeat (4) period(3'b111);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b100);
        repeat (2) period(3'b100);
        chk("rr_drained", exp_q.size(), 0);

        // Early pulse while locked.
        exp_q.push_back(3'b001);
        cyc(1'b1, 3'b111);
        cyc(1'b0, 3'b111);
        cyc(1'b0, 3'b111);
        cyc(1'b1, 3'b111);
        chk("early_locked", 32'(locked), 0);
        chk("early_err", 32'(err), 1);
        chk("early_slot", 32'(slot), 0);
        repeat (MULT - 1) cyc(1'b0, 3'b111);
        cyc(1'b1, 3'b111);
        chk("early_relock2", 32'(locked), 0);
        repeat (MULT - 1) cyc(1'b0, 3'b111);
        exp_q.push_back(3'b010);
        cyc(1'b1, 3'b111);
        chk("early_relock3", 32'(locked), 1);
        repeat (MULT - 1) cyc(1'b0, 3'b111);

        // Missing pulse while locked.
        cyc(1'b0, 3'b000);
        chk("miss_locked", 32'(locked), 0);
        chk("miss_err", 32'(err), 2);
        chk("miss_slot", 32'(slot), 0);
        repeat (2) period(3'b000);
        chk("miss_relock2", 32'(locked), 0);
        cyc(1'b1, 3'b000);
        chk("miss_relock3", 32'(locked), 1);
        repeat (MULT - 1) cyc(1'b0, 3'b000);

        // Error counter saturation via repeated early pulses.
        for (int i = 0; i < 254; i++) begin
            cyc(1'b1, 3'b000);
            cyc(1'b0, 3'b000);
            cyc(1'b1, 3'b000);
            repeat (MULT - 1) cyc(1'b0, 3'b000);
            period(3'b000);
            cyc(1'b1, 3'b000);
            repeat (MULT - 1) cyc(1'b0, 3'b000);
            if (i == 252) chk("sat_reach", 32'(err), 255);
        end
        chk("sat_hold", 32'(err), 255);
        chk("sat_locked", 32'(locked), 1);

        // Async reset while a grant is showing.
        exp_q.push_back(3'b100);
        cyc(1'b1, 3'b111);
        cyc(1'b0, 3'b111);
        #5;
        chk("pre_rst_gnt", 32'(gnt), 32'(3'b100));
        rst_n = 1'b0;
        req   = '0;
        #1;
        chk("arst_gnt", 32'(gnt), 0);
        chk("arst_locked", 32'(locked), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_slot", 32'(slot), 0);
        #1;
        rst_n = 1'b1;
        repeat (2) cyc(1'b0, 3'b000);
        repeat (2) period(3'b000);
        cyc(1'b1, 3'b000);
        chk("post_rst_locked", 32'(locked), 1);
        repeat (MULT - 1) cyc(1'b0, 3'b000);
        exp_q.push_back(3'b001);
        period(3'b111);
        period(3'b000);
        chk("final_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
